// File: rtl/pixel_threshold_stream.sv
// pixel_threshold_stream
//   Streaming pixel threshold filter. Accepts one pixel per cycle over a
//   valid/ready handshake and applies one of four threshold modes against
//   lower/upper thresholds. The result is registered, so it appears one cycle
//   after accept. Config writes land in shadow registers and are committed to
//   the active set only at frame boundaries. A saturating per-frame count of
//   passing pixels is published when the last pixel of each frame is accepted.
//
// Ports
//   clk, rst           rising-edge clock, async active-high reset
//   cfg_we/addr/data   shadow config write (0 lo, 1 hi, 2 mode, 3 dropped)
//   in_valid/ready     input handshake; in_data pixel, in_last end of frame
//   out_valid/ready    output handshake; out_data filtered pixel,
//                      out_last end of frame, out_pass pass predicate
//   frame_count        passing-pixel count of the last completed frame
//   frame_done         one-cycle pulse when frame_count updates

module pixel_threshold_stream #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       COUNT_W   = 20,
    parameter logic [DATA_W-1:0] THR_RESET = DATA_W'(8'h80)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [DATA_W-1:0]  cfg_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               out_pass,
    output logic [COUNT_W-1:0] frame_count,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        ModeToZero    = 2'd0,
        ModeBinary    = 2'd1,
        ModeBand      = 2'd2,
        ModeInvBinary = 2'd3
    } mode_e;

    localparam logic [DATA_W-1:0]  PixMax = '1;
    localparam logic [COUNT_W-1:0] CntMax = '1;

    // Shadow (written by cfg port) and active (used by datapath) settings
    logic [DATA_W-1:0] lo_sh_q, hi_sh_q;
    mode_e             mode_sh_q;
    logic [DATA_W-1:0] lo_q, hi_q;
    mode_e             mode_q;

    logic               in_frame_q;
    logic [COUNT_W-1:0] acc_q;

    logic               accept;
    logic               commit;
    logic               pix_pass;
    logic [DATA_W-1:0]  pix_out;
    logic [COUNT_W-1:0] acc_next;

    // Single output register: free slot, or the occupant leaves this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Commit on the last pixel of a frame, or on any idle cycle between frames
    assign commit = (accept && in_last) || (!in_frame_q && !accept);

    always_comb begin
        pix_pass = 1'b0;
        pix_out  = '0;
        unique case (mode_q)
            ModeToZero: begin
                pix_pass = in_data > lo_q;
                pix_out  = pix_pass ? in_data : '0;
            end
            ModeBinary: begin
                pix_pass = in_data > lo_q;
                pix_out  = pix_pass ? PixMax : '0;
            end
            ModeBand: begin
                // hi <= lo leaves an empty window, so nothing passes
                pix_pass = (in_data > lo_q) && (in_data <= hi_q);
                pix_out  = pix_pass ? in_data : '0;
            end
            ModeInvBinary: begin
                pix_pass = in_data <= lo_q;
                pix_out  = pix_pass ? PixMax : '0;
            end
        endcase
    end

    // Saturating increment of the running pass count
    always_comb begin
        acc_next = acc_q;
        if (pix_pass && (acc_q != CntMax)) begin
            acc_next = acc_q + COUNT_W'(1);
        end
    end

    // Shadow config registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_sh_q   <= THR_RESET;
            hi_sh_q   <= PixMax;
            mode_sh_q <= ModeToZero;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    lo_sh_q   <= cfg_data;
                2'd1:    hi_sh_q   <= cfg_data;
                2'd2:    mode_sh_q <= mode_e'(cfg_data[1:0]);
                default: ;
            endcase
        end
    end

    // Active config; nonblocking read of shadow means a same-cycle cfg write
    // waits for the following commit opportunity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q   <= THR_RESET;
            hi_q   <= PixMax;
            mode_q <= ModeToZero;
        end else if (commit) begin
            lo_q   <= lo_sh_q;
            hi_q   <= hi_sh_q;
            mode_q <= mode_sh_q;
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_pass  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= pix_out;
            out_last  <= in_last;
            out_pass  <= pix_pass;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Frame tracking and pass counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_q  <= 1'b0;
            acc_q       <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                in_frame_q <= !in_last;
                if (in_last) begin
                    frame_count <= acc_next;
                    acc_q       <= '0;
                    frame_done  <= 1'b1;
                end else begin
                    acc_q <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_threshold_stream.sv
// Directed bench for pixel_threshold_stream: table of single-pixel frames for
// every mode, then hand-written sequences for mid-frame config, counter
// saturation (second instance with COUNT_W = 3), backpressure and reset.

module tb_pixel_threshold_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_pass;
    logic [19:0] frame_count;
    logic        frame_done;

    logic        in_ready3, out_valid3, out_last3, out_pass3, frame_done3;
    logic [7:0]  out_data3;
    logic [2:0]  frame_count3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pixel_threshold_stream dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_pass(out_pass), .frame_count(frame_count),
        .frame_done(frame_done)
    );

    pixel_threshold_stream #(.COUNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .out_last(out_last3), .out_pass(out_pass3), .frame_count(frame_count3),
        .frame_done(frame_done3)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] x;
        logic [7:0] exp_out;
        logic       exp_pass;
    } vec_t;

    vec_t       vecs[13];
    logic [7:0] fr_px[64];
    logic [7:0] fr_exp[64];
    logic       fr_pass[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Stream n pixels back-to-back from fr_px with out_ready held high and
    // check each result one cycle later; optional lo write at pixel wr_idx.
    task automatic run_frame(input int n, input int wr_idx, input logic [7:0] wr_lo,
                             input logic [19:0] exp_count);
        out_ready = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("out_valid", 32'(out_valid), 32'd1);
                check("out_data", 32'(out_data), 32'(fr_exp[i-1]));
                check("out_pass", 32'(out_pass), 32'(fr_pass[i-1]));
                check("out_last", 32'(out_last), 32'(i == n));
                check("frame_done", 32'(frame_done), 32'(i == n));
            end
            if (i == n) check("frame_count", 32'(frame_count), 32'(exp_count));
            cfg_we   = (i == wr_idx);
            cfg_addr = 2'd0;
            cfg_data = wr_lo;
            if (i < n) begin
                in_valid = 1'b1;
                in_data  = fr_px[i];
                in_last  = (i == n - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd0);
        check("out_valid_drain", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int         sent;
        int         rx;
        int         dones;
        logic [7:0] x;
        logic [7:0] expq[$];
        logic       lastq[$];
        logic [7:0] e_d;
        logic       e_l;

        vecs[0]  = '{2'd0, 8'h80, 8'hFF, 8'h7F, 8'h00, 1'b0};
        vecs[1]  = '{2'd0, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
        vecs[2]  = '{2'd0, 8'h80, 8'hFF, 8'h81, 8'h81, 1'b1};
        vecs[3]  = '{2'd0, 8'h80, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[4]  = '{2'd1, 8'h40, 8'hFF, 8'h41, 8'hFF, 1'b1};
        vecs[5]  = '{2'd1, 8'h40, 8'hFF, 8'h40, 8'h00, 1'b0};
        vecs[6]  = '{2'd2, 8'h20, 8'h60, 8'h20, 8'h00, 1'b0};
        vecs[7]  = '{2'd2, 8'h20, 8'h60, 8'h21, 8'h21, 1'b1};
        vecs[8]  = '{2'd2, 8'h20, 8'h60, 8'h60, 8'h60, 1'b1};
        vecs[9]  = '{2'd2, 8'h20, 8'h60, 8'h61, 8'h00, 1'b0};
        vecs[10] = '{2'd2, 8'h60, 8'h60, 8'h60, 8'h00, 1'b0};
        vecs[11] = '{2'd3, 8'h10, 8'hFF, 8'h10, 8'hFF, 1'b1};
        vecs[12] = '{2'd3, 8'h10, 8'hFF, 8'h11, 8'h00, 1'b0};

        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_data  = 8'h00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Reset-default thresholds: first four vectors run without config writes
        for (int v = 0; v < 13; v++) begin
            if (v >= 4) begin
                cfg_write(2'd0, vecs[v].lo);
                cfg_write(2'd1, vecs[v].hi);
                cfg_write(2'd2, {6'd0, vecs[v].mode});
            end
            fr_px[0]   = vecs[v].x;
            fr_exp[0]  = vecs[v].exp_out;
            fr_pass[0] = vecs[v].exp_pass;
            run_frame(1, -1, 8'h00, {19'd0, vecs[v].exp_pass});
        end

        // Address 3 must not disturb mode (still INV_BINARY, lo 0x10)
        cfg_write(2'd3, 8'h00);
        fr_px[0] = 8'h05; fr_exp[0] = 8'hFF; fr_pass[0] = 1'b1;
        run_frame(1, -1, 8'h00, 20'd1);

        // Mid-frame write of lo = 0xF0 at pixel 2; old lo = 0x80 holds to the end
        cfg_write(2'd2, 8'h00);
        cfg_write(2'd0, 8'h80);
        cfg_write(2'd1, 8'hFF);
        fr_px[0] = 8'h90; fr_px[1] = 8'h10; fr_px[2] = 8'hF8; fr_px[3] = 8'h85;
        fr_px[4] = 8'hF1; fr_px[5] = 8'h70; fr_px[6] = 8'hFF; fr_px[7] = 8'h81;
        fr_exp[0] = 8'h90; fr_exp[1] = 8'h00; fr_exp[2] = 8'hF8; fr_exp[3] = 8'h85;
        fr_exp[4] = 8'hF1; fr_exp[5] = 8'h00; fr_exp[6] = 8'hFF; fr_exp[7] = 8'h81;
        fr_pass[0] = 1'b1; fr_pass[1] = 1'b0; fr_pass[2] = 1'b1; fr_pass[3] = 1'b1;
        fr_pass[4] = 1'b1; fr_pass[5] = 1'b0; fr_pass[6] = 1'b1; fr_pass[7] = 1'b1;
        run_frame(8, 2, 8'hF0, 20'd6);
        fr_px[0] = 8'hF0; fr_px[1] = 8'h90; fr_px[2] = 8'hF1;
        fr_exp[0] = 8'h00; fr_exp[1] = 8'h00; fr_exp[2] = 8'hF1;
        fr_pass[0] = 1'b0; fr_pass[1] = 1'b0; fr_pass[2] = 1'b1;
        run_frame(3, -1, 8'h00, 20'd1);

        // Counter: 5 of 16 pass, then 10 of 16 pass (COUNT_W = 3 saturates at 7)
        cfg_write(2'd0, 8'h80);
        for (int i = 0; i < 16; i++) begin
            fr_pass[i] = (i % 3 == 0) && (i < 15);
            fr_px[i]   = fr_pass[i] ? 8'(8'h81 + i) : 8'h10;
            fr_exp[i]  = fr_pass[i] ? fr_px[i] : 8'h00;
        end
        run_frame(16, -1, 8'h00, 20'd5);
        check("count3_5", 32'(frame_count3), 32'd5);
        for (int i = 0; i < 16; i++) begin
            fr_pass[i] = (i < 10);
            fr_px[i]   = fr_pass[i] ? 8'(8'hA0 + i) : 8'h05;
            fr_exp[i]  = fr_pass[i] ? fr_px[i] : 8'h00;
        end
        run_frame(16, -1, 8'h00, 20'd10);
        check("count3_sat", 32'(frame_count3), 32'd7);

        // Backpressure: 64-pixel frame, random out_ready, scoreboard queue
        sent  = 0;
        rx    = 0;
        dones = 0;
        for (int cyc = 0; cyc < 2000 && rx < 64; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 64);
            in_data   = 8'(sent * 4 + 3);
            in_last   = (sent == 63);
            #1;
            if (frame_done) dones++;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("bp_extra_output", 32'(rx), 32'd64);
                end else begin
                    e_d = expq.pop_front();
                    e_l = lastq.pop_front();
                    check("bp_out_data", 32'(out_data), 32'(e_d));
                    check("bp_out_last", 32'(out_last), 32'(e_l));
                end
                rx++;
            end
            if (in_valid && in_ready) begin
                x = in_data;
                expq.push_back((x > 8'h80) ? x : 8'h00);
                lastq.push_back(sent == 63);
                sent++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_received", 32'(rx), 32'd64);
        check("bp_frame_done_once", 32'(dones), 32'd1);
        check("bp_frame_count", 32'(frame_count), 32'd32);

        // Reset mid-frame with a stalled output pixel; lo = 0x30 is then lost
        cfg_write(2'd0, 8'h30);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h90;
        in_last   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_frame_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        fr_px[0] = 8'h50; fr_exp[0] = 8'h00; fr_pass[0] = 1'b0;
        fr_px[1] = 8'h81; fr_exp[1] = 8'h81; fr_pass[1] = 1'b1;
        run_frame(2, -1, 8'h00, 20'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
